// File: rtl/lockstep_xcheck_if.sv
// ----------------------------------------------------------------------------
// lockstep_xcheck_if
//   Sample bus shared by the stimulus side and the lockstep comparator.
//   One beat per cycle while sample_valid is high; there is no backpressure.
//
//   sample_valid  ref_data / dut_data / care_mask are valid this cycle
//   ref_data      reference model output
//   dut_data      model-under-test output
//   care_mask     1 = bit takes part in the compare
//
//   master : drives the bus (bench / stimulus generator)
//   slave  : samples the bus (lockstep_xcheck)
// ----------------------------------------------------------------------------
interface lockstep_xcheck_if #(
  parameter int WIDTH = 8
);
  logic             sample_valid;
  logic [WIDTH-1:0] ref_data;
  logic [WIDTH-1:0] dut_data;
  logic [WIDTH-1:0] care_mask;

  modport master (
    output sample_valid,
    output ref_data,
    output dut_data,
    output care_mask
  );

  modport slave (
    input sample_valid,
    input ref_data,
    input dut_data,
    input care_mask
  );
endinterface

// File: rtl/lockstep_xcheck.sv
// ----------------------------------------------------------------------------
// lockstep_xcheck
//   Lockstep comparator for dual-model regressions. Samples a reference bus
//   and a model-under-test bus, delays the compare through a settle pipeline,
//   masks bits, counts mismatches, captures the first failing sample and
//   raises a sticky halt once the error budget is reached.
//
//   Parameters
//     WIDTH    compared bus width (>=1)
//     SETTLE   cycles from sample_valid to compare (>=1)
//     CNT_W    width of the saturating counters
//     MAX_ERR  mismatches before halt asserts (1..2**CNT_W-1)
//
//   Build option
//     XCHK_CASE_EQ_EN  defined: masked compare uses case inequality (!==),
//                      so X/Z must match exactly. Undefined: logical compare,
//                      an X/Z in a cared bit never counts as a failure.
//
//   Ports
//     i_clk           rising-edge clock
//     i_rst           synchronous active-high reset
//     i_en            intake enable; in-flight samples always complete
//     i_smp           sample bus (slave side)
//     o_mismatch      1-cycle pulse: compared sample failed
//     o_err_count     mismatches seen (saturating)
//     o_sample_count  samples compared (saturating)
//     o_first_valid   sticky: first-failure capture is loaded
//     o_first_ref     ref_data of first failing sample
//     o_first_dut     dut_data of first failing sample
//     o_first_idx     sample_count value at the first failure
//     o_halt          sticky: err_count reached MAX_ERR
// ----------------------------------------------------------------------------
module lockstep_xcheck #(
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 1,
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  lockstep_xcheck_if.slave     i_smp,
  output logic                 o_mismatch,
  output logic [CNT_W-1:0]     o_err_count,
  output logic [CNT_W-1:0]     o_sample_count,
  output logic                 o_first_valid,
  output logic [WIDTH-1:0]     o_first_ref,
  output logic [WIDTH-1:0]     o_first_dut,
  output logic [CNT_W-1:0]     o_first_idx,
  output logic                 o_halt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ERR_LIM = CNT_W'(MAX_ERR);

  logic [SETTLE-1:0] r_vld;
  logic [WIDTH-1:0]  r_ref  [SETTLE];
  logic [WIDTH-1:0]  r_dut  [SETTLE];
  logic [WIDTH-1:0]  r_mask [SETTLE];

  logic              r_mismatch;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_smp_cnt;
  logic              r_first_vld;
  logic [WIDTH-1:0]  r_first_ref;
  logic [WIDTH-1:0]  r_first_dut;
  logic [CNT_W-1:0]  r_first_idx;
  logic              r_halt;

  logic              w_take;
  logic              w_cmp;
  logic              w_diff;
  logic [WIDTH-1:0]  w_ref_m;
  logic [WIDTH-1:0]  w_dut_m;
  logic [CNT_W-1:0]  w_err_next;
  logic [CNT_W-1:0]  w_smp_next;

  // halt gates intake only; whatever is already in the pipe still drains
  assign w_take = i_smp.sample_valid & i_en & ~r_halt;
  assign w_cmp  = r_vld[SETTLE-1];

  assign w_ref_m = r_ref[SETTLE-1] & r_mask[SETTLE-1];
  assign w_dut_m = r_dut[SETTLE-1] & r_mask[SETTLE-1];

`ifdef XCHK_CASE_EQ_EN
  assign w_diff = (w_ref_m !== w_dut_m);
`else
  // An ambiguous (X) result is treated as "no mismatch" by the if() below
  assign w_diff = (w_ref_m != w_dut_m);
`endif

  assign w_err_next = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + CNT_W'(1);
  assign w_smp_next = (r_smp_cnt == CNT_MAX) ? r_smp_cnt : r_smp_cnt + CNT_W'(1);

  // Data stages carry no reset: only the valid bits decide whether a stage
  // is ever compared.
  always_ff @(posedge i_clk) begin
    if (w_take) begin
      r_ref[0]  <= i_smp.ref_data;
      r_dut[0]  <= i_smp.dut_data;
      r_mask[0] <= i_smp.care_mask;
    end
    for (int i = 1; i < SETTLE; i++) begin
      r_ref[i]  <= r_ref[i-1];
      r_dut[i]  <= r_dut[i-1];
      r_mask[i] <= r_mask[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld       <= '0;
      r_mismatch  <= 1'b0;
      r_err_cnt   <= '0;
      r_smp_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_ref <= '0;
      r_first_dut <= '0;
      r_first_idx <= '0;
      r_halt      <= 1'b0;
    end else begin
      r_vld[0] <= w_take;
      for (int i = 1; i < SETTLE; i++) begin
        r_vld[i] <= r_vld[i-1];
      end

      r_mismatch <= 1'b0;
      if (w_cmp) begin
        r_smp_cnt <= w_smp_next;
        if (w_diff) begin
          r_mismatch <= 1'b1;
          r_err_cnt  <= w_err_next;
          if (!r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_ref <= r_ref[SETTLE-1];
            r_first_dut <= r_dut[SETTLE-1];
            r_first_idx <= r_smp_cnt;
          end
          if (w_err_next == ERR_LIM) begin
            r_halt <= 1'b1;
          end
        end
      end
    end
  end

  assign o_mismatch     = r_mismatch;
  assign o_err_count    = r_err_cnt;
  assign o_sample_count = r_smp_cnt;
  assign o_first_valid  = r_first_vld;
  assign o_first_ref    = r_first_ref;
  assign o_first_dut    = r_first_dut;
  assign o_first_idx    = r_first_idx;
  assign o_halt         = r_halt;

endmodule

// File: tb/tb_lockstep_xcheck.sv
// ----------------------------------------------------------------------------
// tb_lockstep_xcheck
//   Three comparator instances:
//     u_s1  : SETTLE=1, MAX_ERR=1
//     u_s3  : SETTLE=3, MAX_ERR=4
//     u_sat : SETTLE=1, CNT_W=2, MAX_ERR=3 (counter saturation)
//   Stimulus pushes the expected compare result for every accepted sample;
//   a negedge monitor pops and compares whenever a compare shows up.
// ----------------------------------------------------------------------------
module tb_lockstep_xcheck;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic rst_s1, rst_s3, rst_sat;
  logic en_s1, en_s3, en_sat;

  lockstep_xcheck_if #(.WIDTH(8)) if_s1 ();
  lockstep_xcheck_if #(.WIDTH(8)) if_s3 ();
  lockstep_xcheck_if #(.WIDTH(8)) if_sat ();

  logic        s1_mism, s1_fv, s1_halt;
  logic [15:0] s1_ec, s1_sc, s1_fidx;
  logic [7:0]  s1_fref, s1_fdut;
  logic        s3_mism, s3_fv, s3_halt;
  logic [15:0] s3_ec, s3_sc, s3_fidx;
  logic [7:0]  s3_fref, s3_fdut;
  logic        sat_mism, sat_fv, sat_halt;
  logic [1:0]  sat_ec, sat_sc, sat_fidx;
  logic [7:0]  sat_fref, sat_fdut;

  lockstep_xcheck #(.WIDTH(8), .SETTLE(1), .CNT_W(16), .MAX_ERR(1)) u_s1 (
    .i_clk(clk), .i_rst(rst_s1), .i_en(en_s1), .i_smp(if_s1),
    .o_mismatch(s1_mism), .o_err_count(s1_ec), .o_sample_count(s1_sc),
    .o_first_valid(s1_fv), .o_first_ref(s1_fref), .o_first_dut(s1_fdut),
    .o_first_idx(s1_fidx), .o_halt(s1_halt)
  );

  lockstep_xcheck #(.WIDTH(8), .SETTLE(3), .CNT_W(16), .MAX_ERR(4)) u_s3 (
    .i_clk(clk), .i_rst(rst_s3), .i_en(en_s3), .i_smp(if_s3),
    .o_mismatch(s3_mism), .o_err_count(s3_ec), .o_sample_count(s3_sc),
    .o_first_valid(s3_fv), .o_first_ref(s3_fref), .o_first_dut(s3_fdut),
    .o_first_idx(s3_fidx), .o_halt(s3_halt)
  );

  lockstep_xcheck #(.WIDTH(8), .SETTLE(1), .CNT_W(2), .MAX_ERR(3)) u_sat (
    .i_clk(clk), .i_rst(rst_sat), .i_en(en_sat), .i_smp(if_sat),
    .o_mismatch(sat_mism), .o_err_count(sat_ec), .o_sample_count(sat_sc),
    .o_first_valid(sat_fv), .o_first_ref(sat_fref), .o_first_dut(sat_fdut),
    .o_first_idx(sat_fidx), .o_halt(sat_halt)
  );

  typedef struct {
    int cyc;
    bit mis;
    int sc;
    int ec;
    bit halt;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   m_sc [2];
  int   m_ec [2];
  int   pc3    = 0;
  int   pc_sat = 0;
  int   prev_sc1 = 0;
  int   prev_sc3 = 0;
  bit   four_state;
  bit   case_eq;
  bit   x_fail;
  logic [7:0] probe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check(input int u, input bit mis, input int sc, input int ec, input bit h);
    exp_t e;
    if ((u == 0 && q1.size() == 0) || (u == 1 && q3.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL u%0d unexpected compare: mismatch=%0d sample_count=%0d, expected no compare (cycle %0d)",
               u, mis, sc, cyc);
      return;
    end
    e = (u == 0) ? q1.pop_front() : q3.pop_front();
    chk($sformatf("u%0d compare cycle", u), 32'(cyc), 32'(e.cyc));
    chk($sformatf("u%0d mismatch", u), 32'(mis), 32'(e.mis));
    chk($sformatf("u%0d sample_count", u), 32'(sc), 32'(e.sc));
    chk($sformatf("u%0d err_count", u), 32'(ec), 32'(e.ec));
    chk($sformatf("u%0d halt", u), 32'(h), 32'(e.halt));
  endtask

  // A compare is visible as a mismatch pulse or a rise of sample_count
  always @(negedge clk) begin
    if (s1_mism === 1'b1 || int'(s1_sc) > prev_sc1)
      sb_check(0, s1_mism, int'(s1_sc), int'(s1_ec), s1_halt);
    prev_sc1 = int'(s1_sc);
    if (s3_mism === 1'b1 || int'(s3_sc) > prev_sc3)
      sb_check(1, s3_mism, int'(s3_sc), int'(s3_ec), s3_halt);
    prev_sc3 = int'(s3_sc);
    if (s3_mism === 1'b1) pc3++;
    if (sat_mism === 1'b1) pc_sat++;
  end

  task automatic put(input int u, input logic en, input logic [7:0] r, input logic [7:0] d,
                     input logic [7:0] m, input bit acc, input bit mis);
    exp_t e;
    int   settle;
    int   lim;
    settle = (u == 0) ? 1 : 3;
    lim    = (u == 0) ? 1 : 4;
    if (u == 0) begin
      en_s1 = en; if_s1.sample_valid = 1'b1;
      if_s1.ref_data = r; if_s1.dut_data = d; if_s1.care_mask = m;
    end else begin
      en_s3 = en; if_s3.sample_valid = 1'b1;
      if_s3.ref_data = r; if_s3.dut_data = d; if_s3.care_mask = m;
    end
    if (acc) begin
      m_sc[u]++;
      if (mis) m_ec[u]++;
      e.cyc  = cyc + settle + 1;
      e.mis  = mis;
      e.sc   = m_sc[u];
      e.ec   = m_ec[u];
      e.halt = (m_ec[u] >= lim);
      if (u == 0) q1.push_back(e); else q3.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int u, input int n);
    if (u == 0) begin en_s1 = 1'b1; if_s1.sample_valid = 1'b0; end
    else        begin en_s3 = 1'b1; if_s3.sample_valid = 1'b0; end
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_rst(input int u);
    if (u == 0) begin rst_s1 = 1'b1; if_s1.sample_valid = 1'b0; end
    else        begin rst_s3 = 1'b1; if_s3.sample_valid = 1'b0; end
    repeat (2) begin @(posedge clk); #1; end
    if (u == 0) rst_s1 = 1'b0; else rst_s3 = 1'b0;
    m_sc[u] = 0;
    m_ec[u] = 0;
  endtask

  task automatic put_sat(input logic [7:0] r, input logic [7:0] d);
    if_sat.sample_valid = 1'b1;
    if_sat.ref_data = r; if_sat.dut_data = d; if_sat.care_mask = 8'hFF;
    @(posedge clk); #1;
  endtask

  initial begin
    // Two-state simulators turn X literals into 0, which changes what the
    // X-bearing vectors are expected to do.
    probe = 8'bx;
    four_state = $isunknown(probe);
`ifdef XCHK_CASE_EQ_EN
    case_eq = 1'b1;
`else
    case_eq = 1'b0;
`endif
    x_fail = case_eq || !four_state;

    rst_s1 = 1'b1; rst_s3 = 1'b1; rst_sat = 1'b1;
    en_s1 = 1'b1; en_s3 = 1'b1; en_sat = 1'b1;
    if_s1.sample_valid = 1'b0; if_s1.ref_data = '0; if_s1.dut_data = '0; if_s1.care_mask = '0;
    if_s3.sample_valid = 1'b0; if_s3.ref_data = '0; if_s3.dut_data = '0; if_s3.care_mask = '0;
    if_sat.sample_valid = 1'b0; if_sat.ref_data = '0; if_sat.dut_data = '0; if_sat.care_mask = '0;
    m_sc[0] = 0; m_ec[0] = 0; m_sc[1] = 0; m_ec[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_s1 = 1'b0; rst_s3 = 1'b0;
    @(negedge clk);
    chk("reset mismatch", 32'(s1_mism), 32'd0);
    chk("reset err_count", 32'(s1_ec), 32'd0);
    chk("reset sample_count", 32'(s1_sc), 32'd0);
    chk("reset first_valid", 32'(s1_fv), 32'd0);
    chk("reset first_ref", 32'(s1_fref), 32'd0);
    chk("reset first_idx", 32'(s1_fidx), 32'd0);
    chk("reset halt", 32'(s1_halt), 32'd0);
    chk("reset s3 sample_count", 32'(s3_sc), 32'd0);
    @(posedge clk); #1;

    // clean samples, then a failing one offered with en low
    for (int i = 0; i < 4; i++) put(0, 1'b1, 8'hA5, 8'hA5, 8'hFF, 1'b1, 1'b0);
    put(0, 1'b0, 8'h80, 8'h00, 8'hFF, 1'b0, 1'b0);
    idle(0, 4);
    chk("t1 sample_count", 32'(s1_sc), 32'd4);
    chk("t1 err_count", 32'(s1_ec), 32'd0);
    chk("t1 halt", 32'(s1_halt), 32'd0);
    chk("t1 first_valid", 32'(s1_fv), 32'd0);

    // third sample fails, budget of one -> halt, later samples ignored
    do_rst(0);
    put(0, 1'b1, 8'hA5, 8'hA5, 8'hFF, 1'b1, 1'b0);
    put(0, 1'b1, 8'h3C, 8'h3C, 8'hFF, 1'b1, 1'b0);
    put(0, 1'b1, 8'h80, 8'h00, 8'hFF, 1'b1, 1'b1);
    idle(0, 3);
    put(0, 1'b1, 8'hA5, 8'hA5, 8'hFF, 1'b0, 1'b0);
    put(0, 1'b1, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0);
    idle(0, 4);
    chk("t2 first_valid", 32'(s1_fv), 32'd1);
    chk("t2 first_ref", 32'(s1_fref), 32'h80);
    chk("t2 first_dut", 32'(s1_fdut), 32'h00);
    chk("t2 first_idx", 32'(s1_fidx), 32'd2);
    chk("t2 halt", 32'(s1_halt), 32'd1);
    chk("t2 sample_count", 32'(s1_sc), 32'd3);
    chk("t2 err_count", 32'(s1_ec), 32'd1);

    // masking: zero mask, masked-off difference, then full mask
    do_rst(0);
    put(0, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
    put(0, 1'b1, 8'h7F, 8'hFF, 8'h7F, 1'b1, 1'b0);
    put(0, 1'b1, 8'h7F, 8'hFF, 8'hFF, 1'b1, 1'b1);
    idle(0, 4);
    chk("t3 first_idx", 32'(s1_fidx), 32'd2);
    chk("t3 first_dut", 32'(s1_fdut), 32'hFF);
    chk("t3 err_count", 32'(s1_ec), 32'd1);

    // X in cared bits
    do_rst(0);
    put(0, 1'b1, 8'b1xxxxxxx, 8'b1xxxxxxx, 8'hFF, 1'b1, 1'b0);
    put(0, 1'b1, 8'b1xxxxxxx, 8'b11111111, 8'hFF, 1'b1, x_fail);
    idle(0, 4);
    chk("t4 err_count", 32'(s1_ec), 32'(x_fail));
    chk("t4 sample_count", 32'(s1_sc), 32'd2);

    // SETTLE=3: six back-to-back failures, halt after the fourth compare
    do_rst(1);
    for (int i = 0; i < 6; i++) put(1, 1'b1, 8'(8'h10 + i), 8'h00, 8'hFF, 1'b1, 1'b1);
    idle(1, 8);
    put(1, 1'b1, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0);
    idle(1, 6);
    chk("t5 err_count", 32'(s3_ec), 32'd6);
    chk("t5 sample_count", 32'(s3_sc), 32'd6);
    chk("t5 halt", 32'(s3_halt), 32'd1);
    chk("t5 first_ref", 32'(s3_fref), 32'h10);
    chk("t5 first_idx", 32'(s3_fidx), 32'd0);

    // reset one cycle after a failing sample drops it
    do_rst(1);
    pc3 = 0;
    put(1, 1'b1, 8'h80, 8'h00, 8'hFF, 1'b0, 1'b0);
    rst_s3 = 1'b1;
    if_s3.sample_valid = 1'b0;
    @(posedge clk); #1;
    rst_s3 = 1'b0;
    idle(1, 8);
    chk("t6 mismatch pulses", 32'(pc3), 32'd0);
    chk("t6 sample_count", 32'(s3_sc), 32'd0);
    chk("t6 err_count", 32'(s3_ec), 32'd0);
    chk("t6 first_valid", 32'(s3_fv), 32'd0);

    // saturation with 2-bit counters
    rst_sat = 1'b0;
    pc_sat = 0;
    for (int i = 0; i < 4; i++) put_sat(8'h5A, 8'h5A);
    for (int i = 0; i < 5; i++) put_sat(8'h01, 8'h00);
    if_sat.sample_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("sat mismatch pulses", 32'(pc_sat), 32'd4);
    chk("sat sample_count", 32'(sat_sc), 32'd3);
    chk("sat err_count", 32'(sat_ec), 32'd3);
    chk("sat halt", 32'(sat_halt), 32'd1);
    chk("sat first_idx", 32'(sat_fidx), 32'd3);

    chk("s1 queue drained", 32'(q1.size()), 32'd0);
    chk("s3 queue drained", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
